// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 write-back register file, x0 hardwired to zero.
// Ports: clk, rst_n (async low), reg_write/write_reg/write_data (write
// port), read_reg1/2 -> read_data1/2 (comb reads), write_count (16b).
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [15:0] write_count
);

  logic [31:0] regs_q [32];
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        commit;

  // Writes to x0 are dropped and not counted.
  assign commit = reg_write && (write_reg != 5'd0);
  assign cnt_d  = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (commit) begin
      regs_q[write_reg] <= write_data;
      cnt_q             <= cnt_d;
    end
  end

  logic [31:0] rd1_q;
  logic [31:0] rd2_q;

  assign rd1_q = (read_reg1 == 5'd0) ? 32'h0 : regs_q[read_reg1];
  assign rd2_q = (read_reg2 == 5'd0) ? 32'h0 : regs_q[read_reg2];

`ifdef REG_FILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Gate with rst_n so nothing leaks out while held in reset.
  assign fwd1 = rst_n && commit && (read_reg1 == write_reg);
  assign fwd2 = rst_n && commit && (read_reg2 == write_reg);

  always_comb begin
    read_data1 = rd1_q;
    read_data2 = rd2_q;
    if (fwd1) read_data1 = write_data;
    if (fwd2) read_data2 = write_data;
  end
`else
  always_comb begin
    read_data1 = rd1_q;
    read_data2 = rd2_q;
  end
`endif

  assign write_count = cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized self-checking bench for reg_file_wb
// against an array-based reference model.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [15:0] write_count;

  reg_file_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [31:0] mem [32];
  int          cnt;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    if (idx == 0) return 32'h0;
    if (!rst_n) return 32'h0;
    if (BYP && reg_write && write_reg != 0 && idx == int'(write_reg))
      return write_data;
    return mem[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    cnt = 0;
  endtask

  // Apply current inputs to model at the edge.
  task automatic model_edge();
    if (rst_n && reg_write && write_reg != 0) begin
      mem[write_reg] = write_data;
      cnt = (cnt + 1) % 65536;
    end
  endtask

  task automatic rd_chk(input string tag,
                        input logic [4:0] a,
                        input logic [4:0] b);
    read_reg1 = a;
    read_reg2 = b;
    #1;
    chk({tag, "_rd1"}, read_data1, model_rd(a));
    chk({tag, "_rd2"}, read_data2, model_rd(b));
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = d;
    @(posedge clk);
    model_edge();
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    reg_write = 1'b0;
    write_reg = '0;
    write_data = '0;
    read_reg1 = '0;
    read_reg2 = '0;
    model_clear();

    // Writes held in reset must be ignored.
    @(negedge clk);
    reg_write = 1'b1;
    write_reg = 5'd7;
    write_data = 32'hCAFEF00D;
    read_reg1 = 5'd7;
    #1;
    chk("rst_fwd", read_data1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reg_write = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_chk("rst_all", 5'(i), 5'(31 - i));
    end
    chk("rst_cnt", {16'h0, write_count}, 32'h0);

    wr(5'd1, 32'hDEADBEEF);
    wr(5'd2, 32'h12345678);
    rd_chk("basic", 5'd1, 5'd2);
    chk("basic_r1", read_data1, 32'hDEADBEEF);
    chk("basic_cnt", {16'h0, write_count}, 32'd2);

    wr(5'd0, 32'hFFFFFFFF);
    rd_chk("zero", 5'd0, 5'd0);
    chk("zero_cnt", {16'h0, write_count}, 32'd2);

    // Same-cycle read of the register being written.
    @(negedge clk);
    reg_write = 1'b1;
    write_reg = 5'd5;
    write_data = 32'hA5A5A5A5;
    read_reg1 = 5'd5;
    read_reg2 = 5'd5;
    #1;
    chk("same_pre1", read_data1, BYP ? 32'hA5A5A5A5 : 32'h0);
    chk("same_pre2", read_data2, read_data1);
    @(posedge clk);
    model_edge();
    #1;
    reg_write = 1'b0;
    #1;
    chk("same_post", read_data1, 32'hA5A5A5A5);

    // x0 never forwarded.
    @(negedge clk);
    reg_write = 1'b1;
    write_reg = 5'd0;
    write_data = 32'h55AA55AA;
    read_reg1 = 5'd0;
    #1;
    chk("x0_fwd", read_data1, 32'h0);
    @(posedge clk);
    model_edge();
    #1;
    reg_write = 1'b0;

    // Async reset pulse between edges.
    wr(5'd31, 32'h1);
    rd_chk("pre_arst", 5'd31, 5'd5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    rd_chk("arst", 5'd31, 5'd1);
    chk("arst_cnt", {16'h0, write_count}, 32'h0);
    rst_n = 1'b1;
    #1;
    rd_chk("arst_rel", 5'd5, 5'd2);

    wr(5'd31, 32'h00000001);
    wr(5'd16, 32'h80000000);
    rd_chk("ext", 5'd31, 5'd16);
    chk("ext_r16", read_data2, 32'h80000000);
    rd_chk("ext30", 5'd30, 5'd16);
    chk("ext_r30", read_data1, 32'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg
                                               : 5'($urandom_range(0, 31));
      read_reg2  = 5'($urandom_range(0, 31));
      #1;
      chk("rnd_rd1", read_data1, model_rd(int'(read_reg1)));
      chk("rnd_rd2", read_data2, model_rd(int'(read_reg2)));
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_cnt", {16'h0, write_count}, 32'(cnt));
    end
    for (int i = 0; i < 32; i++) begin
      reg_write = 1'b0;
      rd_chk("rnd_dump", 5'(i), 5'(i));
    end

    // Drive the counter to 16'hFFFF then wrap.
    @(negedge clk);
    reg_write = 1'b1;
    for (int i = cnt; i < 65536; i++) begin
      write_reg  = 5'((i % 31) + 1);
      write_data = 32'(i);
      @(posedge clk);
      model_edge();
      if (cnt == 65535) begin
        #1;
        chk("cnt_ffff", {16'h0, write_count}, 32'h0000FFFF);
      end
      @(negedge clk);
    end
    reg_write = 1'b0;
    #1;
    chk("cnt_wrap", {16'h0, write_count}, 32'(cnt));
    chk("cnt_zero", {16'h0, write_count}, 32'h0);
    rd_chk("wrap_rd", 5'd1, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
